// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and command opcodes.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [1:0] op_t;

  localparam op_t OP_START  = 2'b00;
  localparam op_t OP_STOP   = 2'b01;
  localparam op_t OP_RESUME = 2'b10;
  localparam op_t OP_CLEAR  = 2'b11;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command channel into the counter sequencer: valid/ready handshake carrying an opcode and limit.
interface counter_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_limit;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_limit,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_limit,
    output cmd_ready
  );

endinterface

// File: rtl/counter_sequencer_datapath.sv
// Count and limit registers for the sequencer; clear takes precedence over increment.
module counter_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             eq
);

  logic [WIDTH-1:0] limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      limit <= '0;
    end else if (load) begin
      limit <= load_value;
    end
  end

  assign eq = (count == limit);

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven FSM that sequences the counter datapath from 0 to a programmed limit.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done
);

  state_t state;
  state_t state_next;
  logic   done_next;
  logic   clr;
  logic   inc;
  logic   load;
  logic   eq;
  logic   accept;

  counter_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .inc        (inc),
    .load       (load),
    .load_value (cmd.cmd_limit),
    .count      (count),
    .eq         (eq)
  );

  assign cmd.cmd_ready = !reset && (state != ST_DONE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      done   <= done_next;
    end
  end

  // Accepted commands win over the terminal event; RESUME in RUN falls through to counting.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    clr        = 1'b0;
    inc        = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && cmd.cmd_op == OP_START) begin
          state_next = ST_RUN;
          clr        = 1'b1;
          load       = 1'b1;
        end else if (accept && cmd.cmd_op == OP_CLEAR) begin
          clr        = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && cmd.cmd_op == OP_START) begin
          clr        = 1'b1;
          load       = 1'b1;
        end else if (accept && cmd.cmd_op == OP_STOP) begin
          state_next = ST_HOLD;
        end else if (accept && cmd.cmd_op == OP_CLEAR) begin
          state_next = ST_IDLE;
          clr        = 1'b1;
        end else if (eq) begin
          done_next  = 1'b1;
          if (AUTO_RELOAD) begin
            clr        = 1'b1;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          inc        = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept && cmd.cmd_op == OP_RESUME) begin
          state_next = ST_RUN;
        end else if (accept && cmd.cmd_op == OP_START) begin
          state_next = ST_RUN;
          clr        = 1'b1;
          load       = 1'b1;
        end else if (accept && cmd.cmd_op == OP_CLEAR) begin
          state_next = ST_IDLE;
          clr        = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_RUN) || (state == ST_HOLD);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: one instance in stop-at-terminal mode, one in auto-reload mode.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count_ar;
  logic             busy_ar;
  logic             done_ar;

  int check_count;
  int error_count;

  counter_sequencer_if #(.WIDTH(WIDTH)) cmd_main ();
  counter_sequencer_if #(.WIDTH(WIDTH)) cmd_ar ();

  assign cmd_main.cmd_valid = cmd_valid;
  assign cmd_main.cmd_op    = cmd_op;
  assign cmd_main.cmd_limit = cmd_limit;
  assign cmd_ar.cmd_valid   = cmd_valid;
  assign cmd_ar.cmd_op      = cmd_op;
  assign cmd_ar.cmd_limit   = cmd_limit;

  counter_sequencer #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_main.slave),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  counter_sequencer #(.WIDTH(WIDTH), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_ar.slave),
    .count (count_ar),
    .busy  (busy_ar),
    .done  (done_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int c, input int b, input int d);
    checkOutput({tag, "_count"}, 32'(count), c);
    checkOutput({tag, "_busy"},  32'(busy),  b);
    checkOutput({tag, "_done"},  32'(done),  d);
  endtask

  // Presents one command for exactly one edge, then withdraws it.
  task automatic applyStimulus(input op_t op, input logic [WIDTH-1:0] limit);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_limit = limit;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count = 0;
    error_count = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = OP_START;
    cmd_limit   = '0;
    step();
    step();

    // Reset values
    checkState("rst", 0, 0, 0);
    checkOutput("rst_ready", 32'(cmd_main.cmd_ready), 0);
    reset = 1'b0;
    step();
    checkOutput("idle_ready", 32'(cmd_main.cmd_ready), 1);

    // 1: START L=3
    applyStimulus(OP_START, 4'd3);
    checkState("t1_start", 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      checkState("t1_run", k, 1, 0);
    end
    step();
    checkState("t1_done", 3, 0, 1);
    checkOutput("t1_ready_done", 32'(cmd_main.cmd_ready), 0);
    step();
    checkState("t1_idle", 3, 0, 0);
    checkOutput("t1_ready_idle", 32'(cmd_main.cmd_ready), 1);

    // 2: START L=5, STOP at 2, hold, RESUME
    applyStimulus(OP_START, 4'd5);
    checkState("t2_start", 0, 1, 0);
    step();
    step();
    checkState("t2_run2", 2, 1, 0);
    applyStimulus(OP_STOP, 4'd0);
    checkState("t2_hold", 2, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      checkState("t2_hold_wait", 2, 1, 0);
    end
    applyStimulus(OP_RESUME, 4'd0);
    checkState("t2_resume", 2, 1, 0);
    for (int k = 3; k <= 5; k++) begin
      step();
      checkState("t2_run", k, 1, 0);
    end
    step();
    checkState("t2_done", 5, 0, 1);
    step();
    checkState("t2_idle", 5, 0, 0);

    // 3: START L=0, START offered during DONE must be refused
    applyStimulus(OP_START, 4'd0);
    checkState("t3_start", 0, 1, 0);
    step();
    checkState("t3_done", 0, 0, 1);
    checkOutput("t3_ready_done", 32'(cmd_main.cmd_ready), 0);
    applyStimulus(OP_START, 4'd7);
    checkState("t3_refused", 0, 0, 0);
    step();
    checkState("t3_idle", 0, 0, 0);

    // 5: STOP in the terminal cycle suppresses done
    applyStimulus(OP_START, 4'd2);
    step();
    step();
    checkState("t5_at_limit", 2, 1, 0);
    applyStimulus(OP_STOP, 4'd0);
    checkState("t5_hold", 2, 1, 0);
    step();
    checkState("t5_hold_wait", 2, 1, 0);
    applyStimulus(OP_RESUME, 4'd0);
    checkState("t5_resume", 2, 1, 0);
    step();
    checkState("t5_done", 2, 0, 1);
    step();

    // CLEAR from IDLE zeroes the held count
    applyStimulus(OP_CLEAR, 4'd0);
    checkState("clr_idle", 0, 0, 0);

    // 6: reset mid-RUN, START during reset ignored
    applyStimulus(OP_START, 4'd9);
    for (int k = 0; k < 4; k++) step();
    checkState("t6_run4", 4, 1, 0);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_START;
    cmd_limit = 4'd3;
    step();
    checkState("t6_reset", 0, 0, 0);
    checkOutput("t6_ready_rst", 32'(cmd_main.cmd_ready), 0);
    step();
    checkState("t6_reset2", 0, 0, 0);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    step();
    checkState("t6_after", 0, 0, 0);

    // 4: auto-reload instance, L=2
    applyStimulus(OP_START, 4'd2);
    checkOutput("t4_start_count", 32'(count_ar), 0);
    checkOutput("t4_start_busy", 32'(busy_ar), 1);
    for (int i = 0; i < 9; i++) begin
      step();
      checkOutput("t4_count", 32'(count_ar), (i + 1) % 3);
      checkOutput("t4_done", 32'(done_ar), ((i + 1) % 3 == 0) ? 1 : 0);
      checkOutput("t4_busy", 32'(busy_ar), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
